// File: rtl/fractal_pkg.sv
// Shared types and constants for the multi-lane escape-time engine.
// Holds the lane state encoding, the lane result record and the 4.0 escape threshold.
package fractal_pkg;

   localparam int ITER_W_MAX    = 16;
   localparam int DEF_FRAC_BITS = 12;

   typedef enum logic [1:0] {
      LS_IDLE = 2'd0,
      LS_ITER = 2'd1,
      LS_DONE = 2'd2
   } lane_state_t;

   // iter is sized for the widest supported counter; narrower lanes zero-extend
   typedef struct packed {
      logic [ITER_W_MAX-1:0] iter;
      logic                  in_set;
      logic [9:0]            x;
      logic [9:0]            y;
   } lane_res_t;

   function automatic logic [63:0] escape_sq(input int frac_bits);
      return 64'd4 << (2 * frac_bits);
   endfunction

   localparam logic [63:0] ESCAPE_SQ = escape_sq(DEF_FRAC_BITS);

endpackage

// File: rtl/fractal_lane.sv
// One iteration lane: IDLE -> ITER (z <- z^2 + c per enabled cycle) -> DONE, result held until ack.
// Escape test uses the full-width |z|^2 before truncation; escape wins over the iteration limit.
module fractal_lane
   import fractal_pkg::*;
#(
   parameter int COORD_WIDTH = 16,
   parameter int FRAC_BITS   = 12,
   parameter int ITER_WIDTH  = 6
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable_i,
   input  logic                          flush_i,
   input  logic                          start_i,
   input  logic                          ack_i,
   input  logic signed [COORD_WIDTH-1:0] zr0_i,
   input  logic signed [COORD_WIDTH-1:0] zi0_i,
   input  logic signed [COORD_WIDTH-1:0] cr_i,
   input  logic signed [COORD_WIDTH-1:0] ci_i,
   input  logic [ITER_WIDTH-1:0]         max_iter_i,
   input  logic [9:0]                    x_i,
   input  logic [9:0]                    y_i,
   output logic                          idle_o,
   output logic                          done_o,
   output lane_res_t                     res_o
);

   localparam int W = COORD_WIDTH;
   localparam logic [1:0] S_IDLE = LS_IDLE;
   localparam logic [1:0] S_ITER = LS_ITER;
   localparam logic [1:0] S_DONE = LS_DONE;
   localparam logic [63:0] ESC_SQ = (FRAC_BITS == DEF_FRAC_BITS) ? ESCAPE_SQ : escape_sq(FRAC_BITS);
   localparam logic signed [2*W:0] ESC_W = $signed((2*W+1)'(ESC_SQ));

   logic [1:0]                st_q, st_d;
   logic signed [W-1:0]       zr_q, zr_d, zi_q, zi_d, cr_q, cr_d, ci_q, ci_d;
   logic [ITER_WIDTH-1:0]     cnt_q, cnt_d, mi_q, mi_d;
   logic                      set_q, set_d;
   logic [9:0]                x_q, x_d, y_q, y_d;
   logic signed [2*W-1:0]     zr2, zi2, zrzi;
   logic signed [2*W:0]       mag, zrzi2;
   logic                      esc;

   always_comb begin
      zr2   = (2*W)'(zr_q) * (2*W)'(zr_q);
      zi2   = (2*W)'(zi_q) * (2*W)'(zi_q);
      zrzi  = (2*W)'(zr_q) * (2*W)'(zi_q);
      mag   = (2*W+1)'(zr2) + (2*W+1)'(zi2);
      zrzi2 = {zrzi, 1'b0};
      esc   = (mag >= ESC_W);

      st_d  = st_q;
      zr_d  = zr_q;
      zi_d  = zi_q;
      cr_d  = cr_q;
      ci_d  = ci_q;
      cnt_d = cnt_q;
      mi_d  = mi_q;
      set_d = set_q;
      x_d   = x_q;
      y_d   = y_q;

      case (st_q)
         S_IDLE: begin
            if (start_i) begin
               st_d  = S_ITER;
               zr_d  = zr0_i;
               zi_d  = zi0_i;
               cr_d  = cr_i;
               ci_d  = ci_i;
               cnt_d = '0;
               mi_d  = max_iter_i;
               set_d = 1'b0;
               x_d   = x_i;
               y_d   = y_i;
            end
         end
         S_ITER: begin
            if (enable_i) begin
               if (esc) begin
                  st_d  = S_DONE;
                  set_d = 1'b0;
               end else if (cnt_q == mi_q) begin
                  st_d  = S_DONE;
                  set_d = 1'b1;
               end else begin
                  zr_d  = W'(zr2 >>> FRAC_BITS) - W'(zi2 >>> FRAC_BITS) + cr_q;
                  zi_d  = W'(zrzi2 >>> FRAC_BITS) + ci_q;
                  cnt_d = cnt_q + ITER_WIDTH'(1);
               end
            end
         end
         S_DONE: begin
            if (ack_i) st_d = S_IDLE;
         end
         default: st_d = S_IDLE;
      endcase
   end

   // flush discards the lane exactly like reset
   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
         st_q  <= S_IDLE;
         zr_q  <= '0;
         zi_q  <= '0;
         cr_q  <= '0;
         ci_q  <= '0;
         cnt_q <= '0;
         mi_q  <= '0;
         set_q <= 1'b0;
         x_q   <= '0;
         y_q   <= '0;
      end else begin
         st_q  <= st_d;
         zr_q  <= zr_d;
         zi_q  <= zi_d;
         cr_q  <= cr_d;
         ci_q  <= ci_d;
         cnt_q <= cnt_d;
         mi_q  <= mi_d;
         set_q <= set_d;
         x_q   <= x_d;
         y_q   <= y_d;
      end
   end

   assign idle_o = (st_q == S_IDLE);
   assign done_o = (st_q == S_DONE);

   always_comb begin
      res_o        = '0;
      res_o.iter   = ITER_W_MAX'(cnt_q);
      res_o.in_set = set_q;
      res_o.x      = x_q;
      res_o.y      = y_q;
   end

endmodule

// File: rtl/fractal_engine_mc.sv
// Multi-lane escape-time engine: round-robin dispatch, strictly in-order retire, N+1 edges for N iterations.
// DONE lanes hold results under out_ready backpressure; FRACTAL_JULIA_EN adds julia_mode/julia_cr/julia_ci.
module fractal_engine_mc
   import fractal_pkg::*;
#(
   parameter int COORD_WIDTH     = 16,
   parameter int FRAC_BITS       = 12,
   parameter int ITER_WIDTH      = 6,
   parameter int LANES           = 2,
   parameter int STEP_SHIFT      = 7,
   parameter int SCREEN_CENTER_X = 320,
   parameter int SCREEN_CENTER_Y = 240
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [9:0]                    pixel_x,
   input  logic [9:0]                    pixel_y,
   input  logic signed [COORD_WIDTH-1:0] center_x,
   input  logic signed [COORD_WIDTH-1:0] center_y,
   input  logic [3:0]                    zoom_level,
   input  logic [ITER_WIDTH-1:0]         max_iter,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ITER_WIDTH-1:0]         out_iter,
   output logic                          out_in_set,
   output logic [9:0]                    out_x,
   output logic [9:0]                    out_y,
   output logic                          busy
`ifdef FRACTAL_JULIA_EN
   ,
   input  logic                          julia_mode,
   input  logic signed [COORD_WIDTH-1:0] julia_cr,
   input  logic signed [COORD_WIDTH-1:0] julia_ci
`endif
);

   localparam int W  = COORD_WIDTH;
   localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int MW = (FRAC_BITS + 12 > W) ? FRAC_BITS + 12 : W;

   logic [PW-1:0]       dp_q, dp_d, rp_q, rp_d;
   logic                run_q;
   logic [LANES-1:0]    idle_w, done_w, start_w, ack_w;
   lane_res_t           res_w [LANES];
   lane_res_t           sel_res;
   logic signed [MW-1:0] dx, dy, mx, my;
   logic signed [W-1:0] map_x, map_y, cr_w, ci_w, zr0_w, zi0_w;
   logic [7:0]          shamt;
   logic                accept, retire, unused_iter;

   // pixel offset scaled into the complex plane, wrapping at COORD_WIDTH
   always_comb begin
      shamt = 8'(STEP_SHIFT) + 8'(zoom_level);
      dx    = $signed(MW'({1'b0, pixel_x})) - MW'(SCREEN_CENTER_X);
      dy    = $signed(MW'({1'b0, pixel_y})) - MW'(SCREEN_CENTER_Y);
      mx    = (dx <<< FRAC_BITS) >>> shamt;
      my    = (dy <<< FRAC_BITS) >>> shamt;
      map_x = center_x + mx[W-1:0];
      map_y = center_y + my[W-1:0];
`ifdef FRACTAL_JULIA_EN
      zr0_w = julia_mode ? map_x : '0;
      zi0_w = julia_mode ? map_y : '0;
      cr_w  = julia_mode ? julia_cr : map_x;
      ci_w  = julia_mode ? julia_ci : map_y;
`else
      zr0_w = '0;
      zi0_w = '0;
      cr_w  = map_x;
      ci_w  = map_y;
`endif
   end

   always_comb begin
      in_ready  = run_q & enable & ~flush & idle_w[dp_q];
      accept    = in_valid & in_ready;
      out_valid = done_w[rp_q];
      sel_res   = res_w[rp_q];
      retire    = out_valid & out_ready & ~flush;
      for (int i = 0; i < LANES; i++) begin
         start_w[i] = accept && (dp_q == PW'(i));
         ack_w[i]   = retire && (rp_q == PW'(i));
      end
      dp_d = dp_q;
      rp_d = rp_q;
      if (flush) begin
         dp_d = '0;
         rp_d = '0;
      end else begin
         if (accept) dp_d = (dp_q == PW'(LANES - 1)) ? '0 : dp_q + PW'(1);
         if (retire) rp_d = (rp_q == PW'(LANES - 1)) ? '0 : rp_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dp_q  <= '0;
         rp_q  <= '0;
         run_q <= 1'b0;
      end else begin
         dp_q  <= dp_d;
         rp_q  <= rp_d;
         run_q <= 1'b1;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      fractal_lane #(
         .COORD_WIDTH (COORD_WIDTH),
         .FRAC_BITS   (FRAC_BITS),
         .ITER_WIDTH  (ITER_WIDTH)
      ) u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .enable_i   (enable),
         .flush_i    (flush),
         .start_i    (start_w[g]),
         .ack_i      (ack_w[g]),
         .zr0_i      (zr0_w),
         .zi0_i      (zi0_w),
         .cr_i       (cr_w),
         .ci_i       (ci_w),
         .max_iter_i (max_iter),
         .x_i        (pixel_x),
         .y_i        (pixel_y),
         .idle_o     (idle_w[g]),
         .done_o     (done_w[g]),
         .res_o      (res_w[g])
      );
   end

   assign out_iter    = sel_res.iter[ITER_WIDTH-1:0];
   assign out_in_set  = sel_res.in_set;
   assign out_x       = sel_res.x;
   assign out_y       = sel_res.y;
   assign busy        = ~&idle_w;
   assign unused_iter = ^sel_res.iter;

endmodule

// File: tb/tb_fractal_engine_mc.sv
// Self-checking bench for fractal_engine_mc: directed vector table, corner sequences, randomized scoreboard.
// Expected results come from a plain-arithmetic escape-time reference model.
module tb_fractal_engine_mc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, enable, flush, in_valid, in_ready, out_valid, out_ready, out_in_set, busy;
   logic [9:0]  pixel_x, pixel_y, out_x, out_y;
   logic [15:0] center_x, center_y;
   logic [3:0]  zoom_level;
   logic [5:0]  max_iter, out_iter;

   int errors = 0;
   int checks = 0;

   fractal_engine_mc #(
      .COORD_WIDTH(16), .FRAC_BITS(12), .ITER_WIDTH(6), .LANES(2),
      .STEP_SHIFT(7), .SCREEN_CENTER_X(320), .SCREEN_CENTER_Y(240)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .pixel_x(pixel_x), .pixel_y(pixel_y),
      .center_x(center_x), .center_y(center_y),
      .zoom_level(zoom_level), .max_iter(max_iter),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_iter(out_iter), .out_in_set(out_in_set),
      .out_x(out_x), .out_y(out_y), .busy(busy)
`ifdef FRACTAL_JULIA_EN
      , .julia_mode(1'b0), .julia_cr(16'h0000), .julia_ci(16'h0000)
`endif
   );

   typedef struct {
      int px, py, cx, zm, mi;
      int it, ins, lat;
   } vec_t;

   vec_t vt[8];
   int   got_x[$];
   int   got_it[$];
   int   exp_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic longint wrap16(input longint v);
      logic signed [15:0] t;
      t = v[15:0];
      return longint'(t);
   endfunction

   // Escape-time iteration on the complex plane in Q.12, 16-bit wrap
   function automatic void ref_pixel(input int px, input int py, input int cx, input int cy,
                                     input int zm, input int mi, output int it, output int ins);
      longint cr, ci, zr, zi, zr2, zi2, nzr;
      cr  = wrap16(longint'(cx) + (((longint'(px) - 320) * 4096) >>> (7 + zm)));
      ci  = wrap16(longint'(cy) + (((longint'(py) - 240) * 4096) >>> (7 + zm)));
      zr  = 0;
      zi  = 0;
      it  = 0;
      ins = 1;
      for (int n = 0; n <= 64; n++) begin
         zr2 = zr * zr;
         zi2 = zi * zi;
         if (zr2 + zi2 >= (64'sd4 <<< 24)) begin
            it = n; ins = 0; return;
         end
         if (n == mi) begin
            it = n; ins = 1; return;
         end
         nzr = wrap16((zr2 >>> 12) - (zi2 >>> 12) + cr);
         zi  = wrap16(((2 * zr * zi) >>> 12) + ci);
         zr  = nzr;
      end
   endfunction

   // called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input int px, input int py, input int cx, input int cy, input int zm, input int mi);
      int t;
      bit ok;
      pixel_x    = 10'(px);
      pixel_y    = 10'(py);
      center_x   = 16'(cx);
      center_y   = 16'(cy);
      zoom_level = 4'(zm);
      max_iter   = 6'(mi);
      in_valid   = 1'b1;
      t  = 0;
      ok = 1'b0;
      while (!ok && t < 1000) begin
         #1;
         ok = in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      in_valid = 1'b0;
      if (!ok) chk("send_accept_timeout", 0, 1);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 300) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic collect(input int n);
      int t;
      t = 0;
      got_x.delete();
      got_it.delete();
      while (got_x.size() < n && t < 500) begin
         if (out_valid && out_ready) begin
            got_x.push_back(int'(out_x));
            got_it.push_back(int'(out_iter));
         end
         @(posedge clk);
         #1;
         t++;
      end
      if (got_x.size() < n) chk("collect_timeout", got_x.size(), n);
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_out_valid"}, out_valid, 0);
      chk({pfx, "_out_iter"}, out_iter, 0);
      chk({pfx, "_out_in_set"}, out_in_set, 0);
      chk({pfx, "_out_x"}, out_x, 0);
      chk({pfx, "_out_y"}, out_y, 0);
      chk({pfx, "_busy"}, busy, 0);
   endtask

   initial begin
      int lat, it, ins, rdy_bad, stab_bad, cap_x, cap_it, t;
      bit seen;

      rst_n = 1'b0; enable = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      pixel_x = '0; pixel_y = '0; center_x = '0; center_y = '0; zoom_level = '0; max_iter = '0;

      //            px   py   cx    zm mi   it ins lat
      vt[0] = '{320, 240, 0,    0, 20, 20, 1, 21};
      vt[1] = '{640, 240, 0,    0, 20, 1,  0, 2};
      vt[2] = '{320, 240, 0,    0, 0,  0,  1, 1};
      vt[3] = '{64,  240, 0,    0, 20, 1,  0, 2};
      vt[4] = '{320, 368, 0,    0, 20, 20, 1, 21};
      vt[5] = '{192, 240, 0,    0, 10, 10, 1, 11};
      vt[6] = '{640, 240, 0,    1, 20, 2,  0, 3};
      vt[7] = '{320, 240, 8192, 0, 20, 1,  0, 2};

      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      chk("reset_in_ready", in_ready, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_reset_in_ready", in_ready, 1);

      for (int i = 0; i < 8; i++) begin
         send(vt[i].px, vt[i].py, vt[i].cx, 0, vt[i].zm, vt[i].mi);
         wait_valid(lat);
         chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
         chk($sformatf("vec%0d_iter", i), out_iter, vt[i].it);
         chk($sformatf("vec%0d_in_set", i), out_in_set, vt[i].ins);
         chk($sformatf("vec%0d_x", i), out_x, vt[i].px);
         chk($sformatf("vec%0d_y", i), out_y, vt[i].py);
         @(posedge clk);
         #1;
      end

      // later lane finishes first, must still retire second
      send(320, 240, 0, 0, 0, 20);
      send(640, 240, 0, 0, 0, 20);
      collect(2);
      chk("order_first_iter", got_it.size() > 0 ? got_it[0] : -1, 20);
      chk("order_second_iter", got_it.size() > 1 ? got_it[1] : -1, 1);

      // backpressure with three requests on two lanes
      out_ready = 1'b0;
      send(320, 240, 0, 0, 0, 3);
      send(640, 240, 0, 0, 0, 20);
      pixel_x = 10'd192; pixel_y = 10'd240; max_iter = 6'd3; in_valid = 1'b1;
      rdy_bad = 0; stab_bad = 0; seen = 1'b0; cap_x = 0; cap_it = 0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         #1;
         if (in_ready) rdy_bad++;
         if (out_valid && !seen) begin
            seen = 1'b1; cap_x = int'(out_x); cap_it = int'(out_iter);
         end else if (seen && (!out_valid || int'(out_x) != cap_x || int'(out_iter) != cap_it)) begin
            stab_bad++;
         end
      end
      chk("bp_in_ready_low_cycles", rdy_bad, 0);
      chk("bp_head_x", cap_x, 320);
      chk("bp_out_unstable_cycles", stab_bad, 0);
      fork
         begin
            t = 0;
            while (!in_ready && t < 200) begin
               @(posedge clk);
               #1;
               t++;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("bp_third_accept", t < 200, 1);
         end
         begin
            out_ready = 1'b1;
            collect(3);
         end
      join
      chk("bp_order_x0", got_x.size() > 0 ? got_x[0] : -1, 320);
      chk("bp_order_x1", got_x.size() > 1 ? got_x[1] : -1, 640);
      chk("bp_order_x2", got_x.size() > 2 ? got_x[2] : -1, 192);
      chk("bp_iter2", got_it.size() > 2 ? got_it[2] : -1, 3);
      @(posedge clk);
      #1;

      // enable low for 10 cycles stretches latency by 10
      send(320, 240, 0, 0, 0, 20);
      repeat (5) @(posedge clk);
      #1;
      enable = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      enable = 1'b1;
      wait_valid(lat);
      chk("stall_latency", lat + 15, 31);
      @(posedge clk);
      #1;

      // flush mid-flight
      send(320, 240, 0, 0, 0, 20);
      send(320, 241, 0, 0, 0, 20);
      repeat (3) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      #1;
      chk("flush_busy", busy, 0);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // flush drops a presented result
      out_ready = 1'b0;
      send(640, 240, 0, 0, 0, 20);
      wait_valid(lat);
      flush = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      #1;
      chk("flush_drop_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      send(100, 200, 0, 0, 0, 0);
      wait_valid(lat);
      chk("post_flush_x", out_x, 100);
      @(posedge clk);
      #1;

      // reset mid-operation with one result waiting
      out_ready = 1'b0;
      send(640, 240, 0, 0, 0, 20);
      send(320, 240, 0, 0, 0, 20);
      repeat (3) @(posedge clk);
      #1;
      chk("pre_reset_out_x", out_x, 640);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk_reset_vals("midreset");
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("midreset_release_in_ready", in_ready, 1);

      // randomized traffic against the reference model
      exp_q.delete();
      fork
         begin
            for (int r = 0; r < 40; r++) begin
               int px, py, cx, cy, zm, mi;
               px = $urandom_range(576, 64);
               py = $urandom_range(479, 0);
               cx = $urandom_range(1023, 0) - 512;
               cy = $urandom_range(1023, 0) - 512;
               zm = $urandom_range(3, 0);
               mi = $urandom_range(30, 0);
               ref_pixel(px, py, cx, cy, zm, mi, it, ins);
               exp_q.push_back((it << 21) | (ins << 20) | (px << 10) | py);
               send(px, py, cx, cy, zm, mi);
            end
         end
         begin
            int got, cyc, e;
            got = 0;
            cyc = 0;
            while (got < 40 && cyc < 20000) begin
               out_ready = ($urandom_range(2, 0) != 0);
               enable    = ($urandom_range(4, 0) != 0);
               if (out_valid && out_ready) begin
                  e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                  chk($sformatf("rand%0d_result", got),
                      (int'(out_iter) << 21) | (int'(out_in_set) << 20) | (int'(out_x) << 10) | int'(out_y), e);
                  got++;
               end
               @(posedge clk);
               #1;
               cyc++;
            end
            enable = 1'b1;
            out_ready = 1'b1;
            if (got < 40) chk("rand_results_count", got, 40);
         end
      join

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
